// File: rtl/downcounter_ctrl_if.sv
// Host-side bundle for the countdown sequencer: control inputs plus the
// registered count/status returned by the sequencer.
`timescale 1ns/1ps
interface downcounter_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, load_val, pause, abort,
    input  count, busy, done, state
  );

  modport slave (
    input  start, load_val, pause, abort,
    output count, busy, done, state
  );
endinterface

// File: rtl/downcounter_ctrl.sv
// Countdown sequencer owning a WIDTH-bit down counter with a DIV-cycle prescaler.
// Optional macro AUTO_RELOAD_EN: DONE reloads the last start value and keeps running.
`timescale 1ns/1ps
module downcounter_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic              clock,
  input  logic              reset,
  downcounter_ctrl_if.slave bus
);

  localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Floor at zero so a stray tick can never wrap the count.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.start) begin
          count_d = bus.load_val;
`ifdef AUTO_RELOAD_EN
          reload_d = bus.load_val;
`endif
          state_d = (bus.load_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          presc_d = '0;
          count_d = sat_dec(count_q);
          if (count_q <= WIDTH'(1)) state_d = DONE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSED: begin
        if (bus.abort) begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        count_d = '0;
        presc_d = '0;
        state_d = IDLE;
`ifdef AUTO_RELOAD_EN
        // A zero reload would immediately complete again; stop instead of looping.
        if (!bus.abort && reload_q != '0) begin
          state_d = RUN;
          count_d = reload_q;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSED);
  assign bus.done  = (state_q == DONE);

endmodule
